// File: rtl/pipeline_pkg.sv
// Purpose: shared types for the pipeline's MEM-stage data-memory interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int DMEM_XLEN = 64;

    // RISC-V load/store funct3 size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic                 we;
        logic [2:0]           funct3;
        logic [DMEM_XLEN-1:0] addr;
        logic [DMEM_XLEN-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_XLEN-1:0] rdata;
        logic                 err;
    } dmem_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_t;

endpackage

// File: rtl/load_store_align.sv
// Purpose: byte-lane alignment for data memory: store masking/shift, load extract/extension, fault flags.
// Latency: purely combinational.
// Backpressure: none; caller qualifies outputs with its own handshake.
// Ports: funct3/isStore/byteOff select the access; wdata -> byteEn + wdataAligned;
//        rawWord -> rdataExt; misaligned/illegal flag rejected accesses.
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic                 isStore,
    input  logic [2:0]           byteOff,
    input  logic [DMEM_XLEN-1:0] wdata,
    input  logic [DMEM_XLEN-1:0] rawWord,
    output logic [7:0]           byteEn,
    output logic [DMEM_XLEN-1:0] wdataAligned,
    output logic                 misaligned,
    output logic                 illegal,
    output logic [DMEM_XLEN-1:0] rdataExt
);

    logic [7:0]           sizeMask;
    logic [DMEM_XLEN-1:0] laneWord;

    // funct3[1:0] is the log2 access size for every legal code
    always_comb begin
        sizeMask   = 8'h01;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin sizeMask = 8'h01; misaligned = 1'b0;          end
            2'b01: begin sizeMask = 8'h03; misaligned = byteOff[0];    end
            2'b10: begin sizeMask = 8'h0F; misaligned = |byteOff[1:0]; end
            2'b11: begin sizeMask = 8'hFF; misaligned = |byteOff;      end
            default: begin sizeMask = 8'h01; misaligned = 1'b0;        end
        endcase
    end

    // unsigned stores do not exist; 111 is reserved for both directions
    assign illegal      = (funct3 == 3'b111) || (isStore && funct3[2]);
    assign byteEn       = sizeMask << byteOff;
    assign wdataAligned = wdata << {byteOff, 3'b000};
    assign laneWord     = rawWord >> {byteOff, 3'b000};

    always_comb begin
        rdataExt = '0;
        case (funct3)
            F3_B:    rdataExt = {{56{laneWord[7]}},  laneWord[7:0]};
            F3_H:    rdataExt = {{48{laneWord[15]}}, laneWord[15:0]};
            F3_W:    rdataExt = {{32{laneWord[31]}}, laneWord[31:0]};
            F3_D:    rdataExt = laneWord;
            F3_BU:   rdataExt = {56'h0, laneWord[7:0]};
            F3_HU:   rdataExt = {48'h0, laneWord[15:0]};
            F3_WU:   rdataExt = {32'h0, laneWord[31:0]};
            default: rdataExt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: MEM-stage data-memory responder; one outstanding load/store with alignment and fault flagging.
// Latency: response valid LATENCY cycles after acceptance; LATENCY+1 cycles minimum per transaction.
// Backpressure: req_ready low while busy; response held stable until rsp_ready.
// Ports: req_* valid/ready request (we, funct3, addr, wdata); rsp_* valid/ready response (rdata, err).
//        XLEN must equal 64 (matches pipeline_pkg types); DEPTH_WORDS is a power of two.
module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmemState_t stateQ, stateD;
    logic [3:0] cntQ, cntD;
    dmem_rsp_t  rspQ, rspD;
    dmem_req_t  req;

    logic [XLEN-1:0]  mem [DEPTH_WORDS];
    logic [IDX_W-1:0] wordIdx;
    logic             outOfRange;
    logic [7:0]       byteEn;
    logic [XLEN-1:0]  storeData;
    logic [XLEN-1:0]  loadData;
    logic             misaligned;
    logic             illegal;
    logic             accErr;
    logic             accept;

    assign req = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

    assign wordIdx    = req.addr[IDX_W+2:3];
    assign outOfRange = |req.addr[XLEN-1:IDX_W+3];

    load_store_align u_align (
        .funct3      (req.funct3),
        .isStore     (req.we),
        .byteOff     (req.addr[2:0]),
        .wdata       (req.wdata),
        .rawWord     (mem[wordIdx]),
        .byteEn      (byteEn),
        .wdataAligned(storeData),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .rdataExt    (loadData)
    );

    assign accErr = illegal || misaligned || outOfRange;
    assign accept = req_valid && req_ready;

    // load data is captured at acceptance so later stores cannot alter it
    assign rspD.err   = accErr;
    assign rspD.rdata = (accErr || req.we) ? '0 : loadData;

    // state register, latency counter and response register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= ST_IDLE;
            cntQ   <= '0;
            rspQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                rspQ <= rspD;
            end
        end
    end

    // memory is not reset; stores commit on the acceptance edge
    always_ff @(posedge clk) begin
        if (accept && req.we && !accErr) begin
            for (int b = 0; b < 8; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end

    // next state
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            ST_IDLE: begin
                if (accept) begin
                    cntD   = LAT_M1;
                    stateD = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    stateD = ST_IDLE;
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    // outputs; req_ready is gated by reset so nothing is accepted during it
    always_comb begin
        req_ready = (stateQ == ST_IDLE) && !reset;
        rsp_valid = (stateQ == ST_RESP);
        rsp_rdata = rspQ.rdata;
        rsp_err   = rspQ.err;
    end

endmodule
